rv32i_mem_arbiter: RTL and testbench

- Shares the single data-memory port of the RV32I core between the instruction-fetch requester and the load/store requester.
- Arbitrates between the two, drives MemAddr/MemRead/MemWrite/addMemControl with a ready handshake and returns read data per requester.
- Flags misaligned or reserved accesses without touching memory, and aborts accesses memory never acknowledges.
- Sits between the CPU core and the unified memory model used by the CPU testbench.

---
 rtl/rv32i_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares the data-memory port between fetch and load/store,
// with starvation guard, pre-access legality check and access timeout.
module rv32i_mem_arbiter #(
    parameter int MAX_WAIT   = 15,
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_err,
    output logic [31:0] MemAddr,
    output logic [31:0] toMem,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  addMemControl,
    input  logic [31:0] fromMem,
    input  logic        mem_ready,
    output logic        busy
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GNT_I   = 2'd1;
    localparam logic [1:0] GNT_D   = 2'd2;
    localparam logic [1:0] ERR_RSP = 2'd3;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int SW = $clog2(STARVE_LIM + 1);

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [31:0]   mem_addr_q, mem_addr_d, to_mem_q, to_mem_d;
    logic          if_valid_q, if_valid_d, if_err_q, if_err_d;
    logic          d_valid_q, d_valid_d, d_err_q, d_err_d;
    logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [1:0]    mem_size_q, mem_size_d;
    logic          grant, done, tmo, stay, arb, i_el, d_el, pick_d, pick_i, i_bad, d_bad;

    always_comb begin
        grant = state_q == GNT_I || state_q == GNT_D;
        done = grant && mem_ready;
        tmo = grant && !mem_ready && wait_q == WW'(MAX_WAIT - 1);
        stay = grant && !mem_ready && !tmo;
        arb = !grant || done;
        // the requester completing on this edge does not compete again on it
        i_el = if_req && !(done && state_q == GNT_I);
        d_el = d_req && !(done && state_q == GNT_D);
        pick_d = d_el && (!i_el || starve_q < SW'(STARVE_LIM));
        pick_i = i_el && !pick_d;
        i_bad = if_addr[1:0] != 2'b00;
        d_bad = d_size == 2'b11 || (d_size == 2'b01 && d_addr[0]) || (d_size == 2'b10 && d_addr[1:0] != 2'b00);
        state_d = state_q;
        wait_d = grant ? wait_q + WW'(1) : wait_q;
        starve_d = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d = d_rdata_q;
        if_valid_d = 1'b0;
        if_err_d = 1'b0;
        d_valid_d = 1'b0;
        d_err_d = 1'b0;
        mem_addr_d = stay ? mem_addr_q : '0;
        to_mem_d = stay ? to_mem_q : '0;
        mem_read_d = stay ? mem_read_q : 1'b0;
        mem_write_d = stay ? mem_write_q : 1'b0;
        mem_size_d = stay ? mem_size_q : 2'b00;
        if (done && state_q == GNT_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = fromMem;
        end
        if (done && state_q == GNT_D) begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_write_q ? d_rdata_q : fromMem;
        end
        if (tmo) begin
            state_d = IDLE;
            if_valid_d = state_q == GNT_I;
            if_err_d = state_q == GNT_I;
            if_rdata_d = state_q == GNT_I ? '0 : if_rdata_q;
            d_valid_d = state_q == GNT_D;
            d_err_d = state_q == GNT_D;
            d_rdata_d = state_q == GNT_D ? '0 : d_rdata_q;
        end
        if (arb) begin
            state_d = IDLE;
            if (pick_d) begin
                starve_d = i_el ? starve_q + SW'(1) : starve_q;
                state_d = d_bad ? ERR_RSP : GNT_D;
                d_valid_d = d_bad;
                d_err_d = d_bad;
                d_rdata_d = d_bad ? '0 : d_rdata_d;
                wait_d = '0;
                mem_addr_d = d_bad ? '0 : d_addr;
                to_mem_d = d_bad ? '0 : d_wdata;
                mem_read_d = !d_bad && !d_we;
                mem_write_d = !d_bad && d_we;
                mem_size_d = d_bad ? 2'b00 : d_size;
            end else if (pick_i) begin
                starve_d = '0;
                state_d = i_bad ? ERR_RSP : GNT_I;
                if_valid_d = i_bad;
                if_err_d = i_bad;
                if_rdata_d = i_bad ? '0 : if_rdata_d;
                wait_d = '0;
                mem_addr_d = i_bad ? '0 : if_addr;
                mem_read_d = !i_bad;
                mem_size_d = i_bad ? 2'b00 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q <= '0;
            starve_q <= '0;
            if_rdata_q <= '0;
            d_rdata_q <= '0;
            if_valid_q <= 1'b0;
            if_err_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_err_q <= 1'b0;
            mem_addr_q <= '0;
            to_mem_q <= '0;
            mem_read_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_size_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            starve_q <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q <= d_rdata_d;
            if_valid_q <= if_valid_d;
            if_err_q <= if_err_d;
            d_valid_q <= d_valid_d;
            d_err_q <= d_err_d;
            mem_addr_q <= mem_addr_d;
            to_mem_q <= to_mem_d;
            mem_read_q <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_size_q <= mem_size_d;
        end
    end

    assign if_rdata = if_rdata_q;
    assign if_valid = if_valid_q;
    assign if_err = if_err_q;
    assign d_rdata = d_rdata_q;
    assign d_valid = d_valid_q;
    assign d_err = d_err_q;
    assign MemAddr = mem_addr_q;
    assign toMem = to_mem_q;
    assign MemRead = mem_read_q;
    assign MemWrite = mem_write_q;
    assign addMemControl = mem_size_q;
    assign busy = state_q == GNT_I || state_q == GNT_D;
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb_rv32i_mem_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_rv32i_mem_arbiter;
    localparam int MAX_WAIT = 15;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, fromMem = '0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] if_rdata, d_rdata, MemAddr, toMem;
    logic        if_valid, if_err, d_valid, d_err, MemRead, MemWrite, busy;
    logic [1:0]  addMemControl;

    rv32i_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
        .MemAddr(MemAddr), .toMem(toMem), .MemRead(MemRead), .MemWrite(MemWrite),
        .addMemControl(addMemControl), .fromMem(fromMem), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns memory (0 none, 1 fetch, 2 data), how long it has waited,
    // and how many arbitrations fetch has lost in a row.
    int          m_owner = 0, m_waits = 0, m_losses = 0, o = 0, w = 0;
    bit          m_store = 0, fin = 0, expd = 0, fe = 0, de = 0;
    logic [31:0] e_if_rdata = '0, e_d_rdata = '0, e_addr = '0, e_wdata = '0;
    logic        e_if_valid = 0, e_if_err = 0, e_d_valid = 0, e_d_err = 0, e_rd = 0, e_wr = 0;
    logic [1:0]  e_size = 2'b00;

    function automatic bit data_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b11) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = 0; m_waits = 0; m_losses = 0; m_store = 0;
            e_if_rdata = '0; e_d_rdata = '0; e_addr = '0; e_wdata = '0;
            e_if_valid = 0; e_if_err = 0; e_d_valid = 0; e_d_err = 0; e_rd = 0; e_wr = 0; e_size = 2'b00;
        end else begin
            o = m_owner;
            fin = o != 0 && mem_ready;
            expd = o != 0 && !mem_ready && m_waits + 1 >= MAX_WAIT;
            e_if_valid = 0; e_if_err = 0; e_d_valid = 0; e_d_err = 0;
            if (fin && o == 1) begin e_if_valid = 1; e_if_rdata = fromMem; end
            if (fin && o == 2) begin e_d_valid = 1; if (!m_store) e_d_rdata = fromMem; end
            if (expd) begin
                if (o == 1) begin e_if_valid = 1; e_if_err = 1; e_if_rdata = '0; end
                else begin e_d_valid = 1; e_d_err = 1; e_d_rdata = '0; end
                m_owner = 0;
            end else if (o != 0 && !fin) m_waits++;
            if (o == 0 || fin) begin
                m_owner = 0;
                fe = if_req && !(fin && o == 1);
                de = d_req && !(fin && o == 2);
                w = 0;
                if (fe && de) begin
                    if (m_losses >= STARVE_LIM) w = 1;
                    else begin w = 2; m_losses++; end
                end else if (de) w = 2;
                else if (fe) w = 1;
                if (w == 1) m_losses = 0;
                if (w == 1 && if_addr % 4 != 0) begin
                    e_if_valid = 1; e_if_err = 1; e_if_rdata = '0;
                end else if (w == 2 && !data_legal(d_size, d_addr)) begin
                    e_d_valid = 1; e_d_err = 1; e_d_rdata = '0;
                end else if (w == 1) begin
                    m_owner = 1; m_waits = 0; m_store = 0;
                    e_addr = if_addr; e_wdata = '0; e_rd = 1; e_wr = 0; e_size = 2'b10;
                end else if (w == 2) begin
                    m_owner = 2; m_waits = 0; m_store = d_we;
                    e_addr = d_addr; e_wdata = d_wdata; e_rd = !d_we; e_wr = d_we; e_size = d_size;
                end
            end
            if (m_owner == 0) begin e_addr = '0; e_wdata = '0; e_rd = 0; e_wr = 0; e_size = 2'b00; end
        end
    end

    always @(negedge clk) begin
        chk("cmp_if_rdata", if_rdata, e_if_rdata);
        chk("cmp_if_valid", 32'(if_valid), 32'(e_if_valid));
        chk("cmp_if_err", 32'(if_err), 32'(e_if_err));
        chk("cmp_d_rdata", d_rdata, e_d_rdata);
        chk("cmp_d_valid", 32'(d_valid), 32'(e_d_valid));
        chk("cmp_d_err", 32'(d_err), 32'(e_d_err));
        chk("cmp_MemAddr", MemAddr, e_addr);
        chk("cmp_toMem", toMem, e_wdata);
        chk("cmp_MemRead", 32'(MemRead), 32'(e_rd));
        chk("cmp_MemWrite", 32'(MemWrite), 32'(e_wr));
        chk("cmp_addMemControl", 32'(addMemControl), 32'(e_size));
        chk("cmp_busy", 32'(busy), 32'(m_owner != 0));
    end

    task automatic await_valid(input bit is_d, input int budget, output bit got);
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (is_d ? d_valid : if_valid) begin got = 1; break; end
        end
        if (!got) chk(is_d ? "await_d_valid" : "await_if_valid", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    bit got;
    int hi;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_MemRead", 32'(MemRead), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        // single fetch, memory answers two cycles after the grant
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        chk("fetch_MemRead", 32'(MemRead), 32'd1);
        chk("fetch_size", 32'(addMemControl), 32'd2);
        chk("fetch_MemAddr", MemAddr, 32'h100);
        @(negedge clk);
        mem_ready = 1; fromMem = 32'h00A00113;
        await_valid(0, 5, got);
        chk("fetch_rdata", if_rdata, 32'h00A00113);
        chk("fetch_err", 32'(if_err), 32'd0);
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        chk("fetch_valid_once", 32'(if_valid), 32'd0);
        // collision: data wins first, fetch follows back-to-back
        if_req = 1; if_addr = 32'h200;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_size = 2'b10;
        @(negedge clk);
        chk("coll_MemWrite", 32'(MemWrite), 32'd1);
        chk("coll_MemRead", 32'(MemRead), 32'd0);
        chk("coll_toMem", toMem, 32'hDEADBEEF);
        chk("coll_MemAddr", MemAddr, 32'h40);
        mem_ready = 1; fromMem = 32'h12345678;
        @(negedge clk);
        chk("coll_d_valid", 32'(d_valid), 32'd1);
        chk("coll_b2b_MemRead", 32'(MemRead), 32'd1);
        chk("coll_b2b_MemAddr", MemAddr, 32'h200);
        d_req = 0; d_we = 0;
        @(negedge clk);
        chk("coll_if_valid", 32'(if_valid), 32'd1);
        chk("coll_if_rdata", if_rdata, 32'h12345678);
        chk("coll_store_keeps_d_rdata", d_rdata, 32'd0);
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        // byte load to give d_rdata a nonzero value
        d_req = 1; d_size = 2'b00; d_addr = 32'h43;
        @(negedge clk);
        chk("ldb_size", 32'(addMemControl), 32'd0);
        mem_ready = 1; fromMem = 32'hCAFEF00D;
        @(negedge clk);
        chk("ldb_rdata", d_rdata, 32'hCAFEF00D);
        d_req = 0; mem_ready = 0;
        @(negedge clk);
        // illegal accesses answered without touching memory
        d_req = 1; d_size = 2'b01; d_addr = 32'h41;
        @(negedge clk);
        chk("mis_half_err", 32'({d_valid, d_err}), 32'd3);
        chk("mis_half_rdata", d_rdata, 32'd0);
        chk("mis_half_MemRead", 32'(MemRead), 32'd0);
        d_req = 0;
        @(negedge clk);
        d_req = 1; d_size = 2'b11; d_addr = 32'h40;
        @(negedge clk);
        chk("rsv_size_err", 32'({d_valid, d_err}), 32'd3);
        d_req = 0;
        @(negedge clk);
        if_req = 1; if_addr = 32'h102;
        @(negedge clk);
        chk("mis_fetch_err", 32'({if_valid, if_err}), 32'd3);
        chk("mis_fetch_rdata", if_rdata, 32'd0);
        chk("mis_fetch_MemRead", 32'(MemRead), 32'd0);
        if_req = 0;
        @(negedge clk);
        // starvation: data keeps asking (reserved size), fetch wins the fifth arbitration
        d_req = 1; d_we = 0; d_size = 2'b11; d_addr = 32'h0;
        if_req = 1; if_addr = 32'h300;
        for (int k = 0; k < STARVE_LIM; k++) begin
            @(negedge clk);
            chk("starve_d_wins", 32'({d_valid, d_err, MemRead}), 32'b110);
        end
        @(negedge clk);
        chk("starve_fetch_MemRead", 32'(MemRead), 32'd1);
        chk("starve_fetch_MemAddr", MemAddr, 32'h300);
        d_req = 0; mem_ready = 1; fromMem = 32'h00000013;
        @(negedge clk);
        chk("starve_fetch_rdata", if_rdata, 32'h13);
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        d_req = 1; if_req = 1;
        @(negedge clk);
        chk("starve_cleared_d_wins", 32'({d_err, MemRead}), 32'b10);
        d_req = 0;
        @(negedge clk);
        chk("starve_cleared_then_fetch", 32'(MemRead), 32'd1);
        mem_ready = 1;
        await_valid(0, 3, got);
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        // timeout: memory never answers the fetch
        if_req = 1; if_addr = 32'h400;
        hi = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (if_valid) break;
            if (MemRead) hi++;
        end
        chk("tmo_read_cycles", hi, MAX_WAIT);
        chk("tmo_err", 32'({if_valid, if_err}), 32'd3);
        chk("tmo_rdata", if_rdata, 32'd0);
        chk("tmo_MemRead", 32'(MemRead), 32'd0);
        if_req = 0;
        @(negedge clk);
        // asynchronous reset in the middle of a store
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h55AA55AA; d_size = 2'b10;
        @(negedge clk);
        chk("rst_pre_MemWrite", 32'(MemWrite), 32'd1);
        #2 reset_n = 0;
        #1;
        chk("rst_async_MemWrite", 32'(MemWrite), 32'd0);
        chk("rst_async_MemAddr", MemAddr, 32'd0);
        chk("rst_async_toMem", toMem, 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        chk("rst_no_d_valid", 32'(d_valid), 32'd0);
        reset_n = 1;
        if_req = 1; if_addr = 32'h500;
        @(negedge clk);
        chk("post_rst_MemAddr", MemAddr, 32'h500);
        mem_ready = 1; fromMem = 32'h00100093;
        await_valid(0, 3, got);
        chk("post_rst_rdata", if_rdata, 32'h00100093);
        if_req = 0; mem_ready = 0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
